// File: rtl/fir_pkg.sv
// fir_pkg -- shared definitions for the time-multiplexed FIR filter.
//   state_t     : FSM states (IDLE, MAC, OUT)
//   idx_width() : tap-index width for a given tap count
//   acc_width() : accumulator width wide enough that a full sum of
//                 TAPS products never overflows
//   saturate()  : clamp a wide signed value into an out_w-bit signed range
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Saturation works on one fixed wide type so a single function serves
  // every parameterisation; 128 bits covers the largest legal accumulator.
  localparam int SAT_W = 128;
  typedef logic signed [SAT_W-1:0] wide_t;

  function automatic int idx_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic wide_t saturate(input wide_t val, input int out_w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
    lo = ~hi;  // -(2^(out_w-1))
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac -- signed multiplier feeding a clearable accumulator.
//   clk      : clock, rising edge
//   rst      : synchronous reset, active low
//   clr      : zero the accumulator (has priority over en)
//   en       : add a*b into the accumulator this cycle
//   a, b     : signed sample / coefficient operands
//   acc_next : accumulator value plus the current product, so the caller
//              can capture the final sum on the same edge it is formed
module fir_mac
  import fir_pkg::*;
#(
  parameter  int TAPS   = 7,
  parameter  int DATA_W = 8,
  parameter  int COEF_W = 8,
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc_next
);

  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]         acc_reg;

  assign prod     = a * b;
  assign acc_next = acc_reg + ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_next;
    end
  end

endmodule

// File: rtl/fir_param.sv
// fir_param -- time-multiplexed FIR, one multiply-accumulate per cycle.
//   y[n] = sum_{k=0}^{TAPS-1} w[k] * x[n-k]   (all signed)
// Ports:
//   clk, rst                  : clock; synchronous reset, active low
//   weight_data/idx/valid     : coefficient write (ready = weight_ready)
//   input_data/valid          : sample stream in  (ready = input_ready)
//   output_data/valid/ready   : result stream out
// Build option:
//   FIR_SAT_EN defined   -> result saturates to the OUT_W signed range
//   FIR_SAT_EN undefined -> result is the low OUT_W bits of the sum (wrap)
// A result appears TAPS cycles after the sample is accepted and is held
// until output_ready; samples and weights are only accepted in IDLE.
module fir_param
  import fir_pkg::*;
#(
  parameter  int TAPS   = 7,
  parameter  int DATA_W = 8,
  parameter  int COEF_W = 8,
  parameter  int OUT_W  = 16,
  localparam int IDX_W  = idx_width(TAPS),
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [COEF_W-1:0] weight_data,
  input  logic [IDX_W-1:0]         weight_idx,
  input  logic                     weight_valid,
  output logic                     weight_ready,
  input  logic signed [DATA_W-1:0] input_data,
  input  logic                     input_valid,
  output logic                     input_ready,
  output logic signed [OUT_W-1:0]  output_data,
  output logic                     output_valid,
  input  logic                     output_ready
);

  state_t state_reg, state_next;

  // Low for the first cycle after reset so the ready outputs stay low
  // until the first edge with rst released.
  logic live_reg;

  logic signed [DATA_W-1:0] x_reg  [TAPS];
  logic signed [DATA_W-1:0] x_next [TAPS];
  // w_reg takes writes; w_act_reg is the snapshot a computation runs on,
  // so a write landing on the acceptance edge only affects later samples.
  logic signed [COEF_W-1:0] w_reg     [TAPS];
  logic signed [COEF_W-1:0] w_next    [TAPS];
  logic signed [COEF_W-1:0] w_act_reg [TAPS];

  logic [IDX_W-1:0]        cnt_reg;
  logic signed [OUT_W-1:0] result_reg;
  logic signed [OUT_W-1:0] result_next;
  logic signed [ACC_W-1:0] acc_next;

  logic sample_acc;
  logic weight_acc;
  logic last_tap;

  assign sample_acc = input_valid && input_ready;
  assign weight_acc = weight_valid && weight_ready;
  assign last_tap   = (state_reg == MAC) && (cnt_reg == IDX_W'(TAPS - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sample_acc)   state_next = MAC;
      MAC:     if (last_tap)     state_next = OUT;
      OUT:     if (output_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    input_ready  = (state_reg == IDLE) && live_reg;
    weight_ready = (state_reg == IDLE) && live_reg;
    output_valid = (state_reg == OUT);
  end

  assign output_data = result_reg;

  // ---------------- per-tap next values ----------------
  // An out-of-range weight_idx matches no tap, so such writes are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign x_next[gi] = sample_acc ? input_data : x_reg[gi];
      end else begin : g_tail
        assign x_next[gi] = sample_acc ? x_reg[gi-1] : x_reg[gi];
      end
      assign w_next[gi] = (weight_acc && (weight_idx == IDX_W'(gi))) ? weight_data : w_reg[gi];
    end
  endgenerate

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      live_reg   <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_reg[i]     <= '0;
        w_reg[i]     <= '0;
        w_act_reg[i] <= '0;
      end
    end else begin
      live_reg <= 1'b1;
      for (int i = 0; i < TAPS; i++) begin
        x_reg[i] <= x_next[i];
        w_reg[i] <= w_next[i];
        if (sample_acc) begin
          w_act_reg[i] <= w_reg[i];  // pre-write value: this sample's weights
        end
      end
      if (sample_acc) begin
        cnt_reg <= '0;
      end else if (state_reg == MAC) begin
        cnt_reg <= cnt_reg + IDX_W'(1);
      end
      if (last_tap) begin
        result_reg <= result_next;
      end
    end
  end

  // ---------------- MAC unit ----------------
  fir_mac #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      (sample_acc),
    .en       (state_reg == MAC),
    .a        (x_reg[cnt_reg]),
    .b        (w_act_reg[cnt_reg]),
    .acc_next (acc_next)
  );

  // The last product is folded in combinationally so the result register
  // loads on the same edge as the final MAC step.
`ifdef FIR_SAT_EN
  assign result_next = OUT_W'(saturate(wide_t'(acc_next), OUT_W));
`else
  assign result_next = OUT_W'(acc_next);
`endif

endmodule

// File: tb/tb_fir_param.sv
module tb_fir_param;

  localparam int TAPS   = 7;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 16;
  localparam int IDX_W  = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic signed [COEF_W-1:0] weight_data = '0;
  logic [IDX_W-1:0]         weight_idx = '0;
  logic                     weight_valid = 1'b0;
  logic                     weight_ready;
  logic signed [DATA_W-1:0] input_data = '0;
  logic                     input_valid = 1'b0;
  logic                     input_ready;
  logic signed [OUT_W-1:0]  output_data;
  logic                     output_valid;
  logic                     output_ready = 1'b0;

  always #5 clk = ~clk;

  fir_param #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .weight_data  (weight_data),
    .weight_idx   (weight_idx),
    .weight_valid (weight_valid),
    .weight_ready (weight_ready),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready)
  );

  typedef struct {
    logic signed [7:0] din;
    longint            exp;
  } vec_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     acc_cyc = 0;
  longint sb[$];
  longint mw[TAPS];
  longint mx[TAPS];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bench reference: ideal signed sum narrowed to OUT_W bits.
  function automatic longint narrow(input longint v);
    logic signed [15:0] t;
`ifdef FIR_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    t = v[15:0];
    return longint'(t);
`endif
  endfunction

  function automatic longint model_push(input longint din);
    longint s;
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = din;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += mw[k] * mx[k];
    return s;
  endfunction

  task automatic model_clear;
    for (int k = 0; k < TAPS; k++) begin
      mw[k] = 0;
      mx[k] = 0;
    end
  endtask

  task automatic write_weight(input logic [2:0] idx, input logic signed [7:0] data);
    weight_valid = 1'b1;
    weight_idx   = idx;
    weight_data  = data;
    check("weight_ready_idle", weight_ready, 1);
    tick;
    weight_valid = 1'b0;
    if (int'(idx) < TAPS) mw[idx] = data;
    $display("weight write idx=%0d data=%0d", idx, data);
  endtask

  task automatic accept(input logic signed [7:0] din, input bit expect_out, input longint exp,
                        input bit wv, input logic [2:0] widx, input logic signed [7:0] wdata);
    int guard;
    guard = 0;
    while (!input_ready && guard < 20) begin
      tick;
      guard++;
    end
    check("input_ready_before_accept", input_ready, 1);
    input_valid  = 1'b1;
    input_data   = din;
    weight_valid = wv;
    weight_idx   = widx;
    weight_data  = wdata;
    if (wv) check("simul_weight_ready", weight_ready, 1);
    if (expect_out) sb.push_back(exp);
    tick;
    acc_cyc      = cyc;
    input_valid  = 1'b0;
    weight_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int     guard;
    longint exp;
    longint held;
    guard = 0;
    while (!output_valid && guard < 40) begin
      tick;
      guard++;
    end
    check("latency", cyc - acc_cyc, TAPS);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: output with no expected value (cycle %0d)", cyc);
      exp = 0;
    end else begin
      exp = sb.pop_front();
    end
    check("output_data", output_data, exp);
    $display("sample result got=%0d exp=%0d latency=%0d", output_data, exp, cyc - acc_cyc);
    held = output_data;
    for (int i = 0; i < hold; i++) begin
      tick;
      check("bp_valid", output_valid, 1);
      check("bp_data", output_data, held);
      check("bp_input_ready", input_ready, 0);
      check("bp_weight_ready", weight_ready, 0);
    end
    output_ready = 1'b1;
    tick;
    output_ready = 1'b0;
    check("release_valid_low", output_valid, 0);
    check("release_idle_ready", input_ready, 1);
  endtask

  task automatic send(input logic signed [7:0] din, input int hold);
    longint exp;
    exp = narrow(model_push(din));
    accept(din, 1'b1, exp, 1'b0, 3'd0, 8'sd0);
    collect(hold);
  endtask

  initial begin
    vec_t             imp_tbl[8];
    vec_t             ovf_tbl[7];
    vec_t             neg_tbl[2];
    longint           exp;
    logic signed [7:0] rd;
    logic signed [7:0] rw;
    logic [2:0]       ri;
    int               nv;

    for (int i = 0; i < 8; i++) begin
      imp_tbl[i].din = (i == 0) ? 8'sd1 : 8'sd0;
      imp_tbl[i].exp = (i < 7) ? longint'(i + 1) : 0;
    end
    for (int i = 0; i < 7; i++) begin
      ovf_tbl[i].din = 8'sd127;
      ovf_tbl[i].exp = narrow(longint'(16129) * longint'(i + 1));
    end
    for (int i = 0; i < 2; i++) begin
      neg_tbl[i].din = 8'sd127;
      neg_tbl[i].exp = narrow(-113792);
    end

    // ---- reset state ----
    rst = 1'b0;
    tick;
    tick;
    check("reset_input_ready", input_ready, 0);
    check("reset_weight_ready", weight_ready, 0);
    check("reset_output_valid", output_valid, 0);
    check("reset_output_data", output_data, 0);
    rst = 1'b1;
    tick;
    check("post_reset_input_ready", input_ready, 1);
    check("post_reset_weight_ready", weight_ready, 1);
    model_clear();

    // ---- impulse response, w = 1..7; idx 7 write must be ignored ----
    for (int k = 0; k < TAPS; k++) write_weight(3'(k), 8'(k + 1));
    write_weight(3'd7, 8'sd100);
    for (int i = 0; i < 8; i++) begin
      void'(model_push(imp_tbl[i].din));
      accept(imp_tbl[i].din, 1'b1, imp_tbl[i].exp, 1'b0, 3'd0, 8'sd0);
      collect(0);
    end

    // ---- weight lockout during MAC ----
    exp = narrow(model_push(1));
    accept(8'sd1, 1'b1, exp, 1'b0, 3'd0, 8'sd0);
    weight_valid = 1'b1;
    weight_idx   = 3'd2;
    weight_data  = 8'sd99;
    check("lockout_weight_ready", weight_ready, 0);
    tick;
    check("lockout_weight_ready_2", weight_ready, 0);
    weight_valid = 1'b0;
    collect(0);
    send(8'sd0, 0);
    send(8'sd0, 0);  // uses w[2]: must still be 3

    // ---- simultaneous weight write and sample acceptance ----
    exp = narrow(model_push(2));
    accept(8'sd2, 1'b1, exp, 1'b1, 3'd0, 8'sd10);
    mw[0] = 10;  // only later samples see the new coefficient
    collect(0);
    send(8'sd1, 0);

    // ---- backpressure: output_ready held low 5 cycles ----
    send(-8'sd3, 5);

    // ---- overflow: all w = 127, history flushed, then seven 127s ----
    for (int k = 0; k < TAPS; k++) write_weight(3'(k), 8'sd127);
    for (int i = 0; i < TAPS; i++) send(8'sd0, 0);
    for (int i = 0; i < 7; i++) begin
      void'(model_push(ovf_tbl[i].din));
      accept(ovf_tbl[i].din, 1'b1, ovf_tbl[i].exp, 1'b0, 3'd0, 8'sd0);
      collect(0);
    end
    for (int k = 0; k < TAPS; k++) write_weight(3'(k), -8'sd128);
    for (int i = 0; i < 2; i++) begin
      void'(model_push(neg_tbl[i].din));
      accept(neg_tbl[i].din, 1'b1, neg_tbl[i].exp, 1'b0, 3'd0, 8'sd0);
      collect(0);
    end

    // ---- random traffic against the reference model ----
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        ri = 3'($urandom_range(0, 7));
        rw = 8'($urandom);
        write_weight(ri, rw);
      end
      rd = 8'($urandom);
      send(rd, (it % 3 == 0) ? 1 : 0);
    end

    // ---- reset in the middle of MAC ----
    accept(8'sd5, 1'b0, 0, 1'b0, 3'd0, 8'sd0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    check("midmac_reset_valid", output_valid, 0);
    check("midmac_reset_input_ready", input_ready, 0);
    check("midmac_reset_weight_ready", weight_ready, 0);
    check("midmac_reset_data", output_data, 0);
    rst = 1'b1;
    model_clear();
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (output_valid) nv++;
    end
    check("midmac_no_output", nv, 0);
    check("midmac_idle_ready", input_ready, 1);
    send(8'sd1, 0);  // weights cleared: zero response
    send(8'sd0, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_param.md
FIR_PARAM -- requirements
Module: fir_param

Interface
REQ-001 Parameter TAPS, 7, number of filter taps (2..64).
REQ-002 Parameter DATA_W, 8, signed input sample width.
REQ-003 Parameter COEF_W, 8, signed coefficient width.
REQ-004 Parameter OUT_W, 16, signed output width (OUT_W <= ACC_W).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 weight_data  in  COEF_W  signed coefficient to load.
REQ-008 weight_idx  in  IDX_W=$clog2(TAPS)  tap index for weight_data.
REQ-009 weight_valid  in  1  coefficient write request.
REQ-010 weight_ready  out  1  coefficient write accepted when high with weight_valid.
REQ-011 input_data  in  DATA_W  signed sample.
REQ-012 input_valid  in  1  sample offered.
REQ-013 input_ready  out  1  sample accepted when high with input_valid.
REQ-014 output_data  out  OUT_W  signed filter result.
REQ-015 output_valid  out  1  output_data holds a result.
REQ-016 output_ready  in  1  downstream accepts result.

Function
REQ-017 The block SHALL be a time-multiplexed FIR with one multiply-accumulate per cycle: y[n] = sum over k=0..TAPS-1 of w[k]*x[n-k], signed.
REQ-018 The FSM SHALL have states IDLE, MAC, OUT.
REQ-019 IDLE: input_ready=1, weight_ready=1; on input_valid the sample SHALL shift into x[0] (x[k] <= x[k-1]), accumulator cleared, tap counter = 0, go to MAC.
REQ-020 MAC: input_ready=0, weight_ready=0; each cycle acc += x[cnt]*w[cnt], cnt increments; after the cycle with cnt = TAPS-1 the result register SHALL load and state goes to OUT.
REQ-021 output_valid SHALL rise exactly TAPS cycles after the input acceptance edge (7 for default).
REQ-022 OUT: output_valid=1, output_data stable, input_ready=0, weight_ready=0, until output_ready=1; on that edge go to IDLE and output_valid falls.
REQ-023 Accumulator width ACC_W = DATA_W+COEF_W+$clog2(TAPS); no intermediate overflow.
REQ-024 Output narrowing per REQ-031/REQ-032.
REQ-025 Weight write with weight_idx >= TAPS SHALL be ignored (no register changes); weight writes in IDLE coinciding with a sample acceptance SHALL take effect before the next computation but not the one just started.
REQ-026 Simultaneous weight_valid and input_valid in IDLE SHALL both be accepted on the same edge.
REQ-027 A computation SHALL use coefficients as they were at its acceptance edge; coefficients cannot change during MAC/OUT.

Reset
REQ-028 With rst=0 on a clock edge: state IDLE, x[] and w[] all 0, acc 0, result 0, output_valid 0, input_ready 0, weight_ready 0.
REQ-029 input_ready and weight_ready SHALL go high on the first edge after rst returns high.
REQ-030 Reset during MAC or OUT SHALL abort the computation; no result is emitted.

Configuration
REQ-031 Macro FIR_SAT_EN defined: result SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-032 FIR_SAT_EN undefined: result SHALL be acc[OUT_W-1:0] (two's-complement wrap).

Structure
REQ-033 Package fir_pkg SHALL hold FSM state enum, ACC_W/IDX_W derivation functions and the saturation function.
REQ-034 Sub-module fir_mac (signed multiplier plus accumulator with clear/enable) SHALL be instantiated once.

Verification (TAPS=7, DATA_W=8, COEF_W=8, OUT_W=16)
REQ-035 Impulse: w = 1..7, inputs 1,0,0,0,0,0,0,0 -> outputs 1,2,3,4,5,6,7,0; each output_valid 7 cycles after acceptance.
REQ-036 Overflow: all w=127, seven inputs 127 -> 7th output 32767 with FIR_SAT_EN, 0xB907 (-18169) without; all w=-128, inputs 127 -> -32768 with FIR_SAT_EN.
REQ-037 Backpressure: output_ready low 5 cycles in OUT -> output_data/output_valid stable, input_ready and weight_ready low; release -> IDLE next cycle.
REQ-038 Weight lockout: weight_valid with idx 2 during MAC -> weight_ready 0, w[2] unchanged; idx 7 in IDLE -> ignored.
REQ-039 Reset mid-MAC: rst=0 at cycle 3 of MAC -> all outputs to reset values, no output_valid pulse, next impulse gives zeros (weights cleared).
